mem_bus_sched: RTL

Two-requester scheduler for the core's single shared memory bus. The instruction fetcher and the execute unit both use the same one-port, 8-bit memory; this block grants exactly one of them per bus transaction and sequences the address phase and data phase. It returns read data with a per-requester valid strobe and supports a fetch flush for discarding an in-flight prefetch. It sits between the fetch/decode-exec stages and the memory.

---
 rtl/mem_bus_sched_if.sv | 41 ++++
 rtl/mem_bus_sched.sv | 106 ++++++++++
 2 files changed

// File: rtl/mem_bus_sched_if.sv
// Bundle of requester, memory and debug signals around the shared-bus scheduler.
// The scheduler side uses modport slave; the requesters/memory side uses modport master.
interface mem_bus_sched_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    // Handshake: a requester raises req and holds it until it sees its one-cycle gnt.
    // It drops req at the edge ending the gnt cycle, or keeps it high for another access.
    // rvalid marks the data phase one cycle after gnt; for an exec write it is the ack.
    logic          req_f;
    logic [AW-1:0] addr_f;
    logic          flush_f;
    logic          req_x;
    logic [AW-1:0] addr_x;
    logic          we_x;
    logic [DW-1:0] wdata_x;
    logic          gnt_f;
    logic          gnt_x;
    logic          rvalid_f;
    logic          rvalid_x;
    logic [DW-1:0] rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic [1:0]    dbg_state;

    modport slave (
        input  req_f, addr_f, flush_f, req_x, addr_x, we_x, wdata_x, mem_rdata,
        output gnt_f, gnt_x, rvalid_f, rvalid_x, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy, dbg_state
    );

    modport master (
        output req_f, addr_f, flush_f, req_x, addr_x, we_x, wdata_x, mem_rdata,
        input  gnt_f, gnt_x, rvalid_f, rvalid_x, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy, dbg_state
    );
endinterface

// File: rtl/mem_bus_sched.sv
// Fetch/exec scheduler for a single-port memory: ADDR phase then DATA phase per access.
// Define MEM_SCHED_FAIRNESS_EN to bound fetch starvation at STARVE_MAX exec grants.
module mem_bus_sched #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 3
) (
    input logic           CLK,
    input logic           RST,
    mem_bus_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state;
    logic          owner_x;
    logic          kill;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;

    logic decide;
    logic any_req;
    logic pick_x;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must be in 1..15");
    end

    assign decide  = (state != ADDR);
    assign any_req = bus.req_f | bus.req_x;

`ifdef MEM_SCHED_FAIRNESS_EN
    logic [3:0] streak;

    // Fetch overrides exec priority only once exec has won STARVE_MAX times in a row over it.
    assign pick_x = bus.req_x & ~(bus.req_f & (streak == 4'(STARVE_MAX)));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            streak <= 4'd0;
        end else if (decide && any_req) begin
            if (pick_x && bus.req_f)
                streak <= (streak == 4'd15) ? streak : streak + 4'd1;
            else
                streak <= 4'd0;
        end
    end
`else
    assign pick_x = bus.req_x;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            owner_x <= 1'b0;
            kill    <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state)
                ADDR: begin
                    state <= DATA;
                    if (!owner_x && bus.flush_f)
                        kill <= 1'b1;
                end
                default: begin
                    // A flush seen during DATA only needs the combinational mask below.
                    kill <= 1'b0;
                    if (any_req) begin
                        state   <= ADDR;
                        owner_x <= pick_x;
                        if (pick_x) begin
                            addr_q  <= bus.addr_x;
                            we_q    <= bus.we_x;
                            wdata_q <= bus.wdata_x;
                        end else begin
                            addr_q  <= bus.addr_f;
                            we_q    <= 1'b0;
                            wdata_q <= '0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.gnt_f     = (state == ADDR) & ~owner_x;
    assign bus.gnt_x     = (state == ADDR) & owner_x;
    assign bus.mem_en    = (state == ADDR);
    assign bus.mem_we    = (state == ADDR) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state != IDLE);
    assign bus.dbg_state = state;

    assign bus.rvalid_f = (state == DATA) & ~owner_x & ~kill & ~bus.flush_f;
    assign bus.rvalid_x = (state == DATA) & owner_x;
    assign bus.rdata    = (bus.rvalid_f | bus.rvalid_x) ? bus.mem_rdata : '0;
endmodule
